// File: rtl/bcd_pkg.sv
// Shared BCD definitions for the two-digit counter and the downstream
// BCD-to-one-hot decoder.
//   bcd_t            : one BCD digit (4 bits, legal range BCD_MIN..BCD_MAX)
//   BCD_MIN/BCD_MAX  : digit limits
//   bcd_valid()      : true when a nibble holds a legal BCD digit
package bcd_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MIN = 4'd0;
    localparam bcd_t BCD_MAX = 4'd9;

    function automatic logic bcd_valid(input bcd_t v);
        return (v <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One registered BCD digit with load, up/down step and rollover.
// Ports:
//   clk, reset     : clock, synchronous active-high reset (digit -> 0)
//   step_i         : advance the digit one position this cycle
//   d_i            : direction, 0 = up, 1 = down
//   load_i         : load load_digit_i (wins over step_i)
//   load_digit_i   : digit to load, assumed already validated
//   digit_o        : registered digit value
//   carry_o        : combinational, up step rolling 9 -> 0
//   borrow_o       : combinational, down step rolling 0 -> 9
module bcd_digit
    import bcd_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic step_i,
    input  logic d_i,
    input  logic load_i,
    input  bcd_t load_digit_i,
    output bcd_t digit_o,
    output logic carry_o,
    output logic borrow_o
);

    bcd_t digit_q;
    bcd_t digit_d;

    always_comb begin
        digit_d = digit_q;
        if (load_i) begin
            digit_d = load_digit_i;
        end else if (step_i) begin
            if (!d_i) begin
                digit_d = (digit_q == BCD_MAX) ? BCD_MIN : bcd_t'(digit_q + 4'd1);
            end else begin
                digit_d = (digit_q == BCD_MIN) ? BCD_MAX : bcd_t'(digit_q - 4'd1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            digit_q <= BCD_MIN;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit_o  = digit_q;
    assign carry_o  = step_i & ~d_i & (digit_q == BCD_MAX);
    assign borrow_o = step_i &  d_i & (digit_q == BCD_MIN);

endmodule

// File: rtl/bcd_counter2.sv
// Two-digit (00-99) BCD up/down counter with validated load, wrap or
// saturate at the limits, terminal-count pulse and load-error pulse.
// Parameters:
//   WRAP     : 1 = wrap 99<->00, 0 = saturate at 99 / 00
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   en         : count enable, one step per cycle
//   d          : direction, 0 = up, 1 = down
//   load       : load request (beats en)
//   load_val   : {tens, ones} BCD value to load
//   ones, tens : registered BCD digits
//   tc         : registered pulse, one cycle after any step taken at a limit
//   load_err   : registered pulse, one cycle after a load with a non-BCD nibble
module bcd_counter2
    import bcd_pkg::*;
#(
    parameter bit WRAP = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       d,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic       tc,
    output logic       load_err
);

    bcd_t ones_val;
    bcd_t tens_val;
    logic ones_carry;
    logic ones_borrow;
    logic tens_carry;
    logic tens_borrow;

    logic load_ok;
    logic digit_load;
    logic step_req;
    logic at_max;
    logic at_min;
    logic limit_hit;
    logic ones_step;
    logic tens_step;

    logic tc_q;
    logic tc_d;
    logic load_err_q;
    logic load_err_d;

    assign load_ok    = bcd_valid(load_val[3:0]) & bcd_valid(load_val[7:4]);
    assign digit_load = load & load_ok;

    // A rejected load still blocks the step for that cycle.
    assign step_req   = en & ~load;

    assign at_max     = (ones_val == BCD_MAX) & (tens_val == BCD_MAX);
    assign at_min     = (ones_val == BCD_MIN) & (tens_val == BCD_MIN);
    assign limit_hit  = d ? at_min : at_max;

    // In saturate mode the step at the limit is swallowed; tc still fires.
    assign ones_step  = step_req & ~(limit_hit & (WRAP == 1'b0));
    assign tens_step  = ones_carry | ones_borrow;

    assign tc_d       = step_req & limit_hit;
    assign load_err_d = load & ~load_ok;

    bcd_digit u_ones (
        .clk          (clk),
        .reset        (reset),
        .step_i       (ones_step),
        .d_i          (d),
        .load_i       (digit_load),
        .load_digit_i (load_val[3:0]),
        .digit_o      (ones_val),
        .carry_o      (ones_carry),
        .borrow_o     (ones_borrow)
    );

    bcd_digit u_tens (
        .clk          (clk),
        .reset        (reset),
        .step_i       (tens_step),
        .d_i          (d),
        .load_i       (digit_load),
        .load_digit_i (load_val[7:4]),
        .digit_o      (tens_val),
        .carry_o      (tens_carry),
        .borrow_o     (tens_borrow)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            tc_q       <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            tc_q       <= tc_d;
            load_err_q <= load_err_d;
        end
    end

    // Tens carry/borrow feed nothing: the limit is detected on the full count.
    logic unused_tens_flags;
    assign unused_tens_flags = tens_carry ^ tens_borrow;

    assign ones     = ones_val;
    assign tens     = tens_val;
    assign tc       = tc_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_counter2.sv
module tb_bcd_counter2;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       d;
    logic       load;
    logic [7:0] load_val;

    logic [3:0] w_ones, w_tens, s_ones, s_tens;
    logic       w_tc, w_err, s_tc, s_err;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    bcd_counter2 #(.WRAP(1'b1)) dut_w (
        .clk(clk), .reset(reset), .en(en), .d(d), .load(load), .load_val(load_val),
        .ones(w_ones), .tens(w_tens), .tc(w_tc), .load_err(w_err)
    );

    bcd_counter2 #(.WRAP(1'b0)) dut_s (
        .clk(clk), .reset(reset), .en(en), .d(d), .load(load), .load_val(load_val),
        .ones(s_ones), .tens(s_tens), .tc(s_tc), .load_err(s_err)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs and sample just after the edge.
    task automatic cyc(input logic r, input logic ld, input logic [7:0] lv,
                       input logic e, input logic dir);
        reset = r; load = ld; load_val = lv; en = e; d = dir;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] bcd2(input int v);
        logic [3:0] t, o;
        t = 4'(v / 10);
        o = 4'(v % 10);
        return {t, o};
    endfunction

    // Expected {tens,ones}, tc, load_err for both instances.
    task automatic exp_both(input string tag,
                            input logic [7:0] wc, input logic wt, input logic we,
                            input logic [7:0] sc, input logic st, input logic se);
        chk({tag, " w.cnt"}, {w_tens, w_ones}, wc);
        chk({tag, " w.tc"},  {7'd0, w_tc},     {7'd0, wt});
        chk({tag, " w.err"}, {7'd0, w_err},    {7'd0, we});
        chk({tag, " s.cnt"}, {s_tens, s_ones}, sc);
        chk({tag, " s.tc"},  {7'd0, s_tc},     {7'd0, st});
        chk({tag, " s.err"}, {7'd0, s_err},    {7'd0, se});
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; d = 1'b0; load = 1'b0; load_val = 8'h00;

        // Reset, with load and en asserted to show they are ignored.
        cyc(1, 1, 8'h55, 1, 0);
        cyc(1, 0, 8'h00, 1, 0);
        exp_both("reset", 8'h00, 0, 0, 8'h00, 0, 0);

        // Count up 100 cycles: wrap returns to 00, saturate sticks at 99.
        for (int i = 0; i < 100; i++) begin
            cyc(0, 0, 8'h00, 1, 0);
            exp_both($sformatf("up%0d", i),
                     bcd2((i + 1) % 100), (i == 99), 0,
                     bcd2((i + 1 > 99) ? 99 : i + 1), (i == 99), 0);
        end

        // Idle: hold, tc clears.
        cyc(0, 0, 8'h00, 0, 0);
        exp_both("idle", 8'h00, 0, 0, 8'h99, 0, 0);

        // Load 09, step up (carry), step down (borrow).
        cyc(0, 1, 8'h09, 0, 0);
        exp_both("ld09", 8'h09, 0, 0, 8'h09, 0, 0);
        cyc(0, 0, 8'h00, 1, 0);
        exp_both("carry", 8'h10, 0, 0, 8'h10, 0, 0);
        cyc(0, 0, 8'h00, 1, 1);
        exp_both("borrow", 8'h09, 0, 0, 8'h09, 0, 0);
        cyc(0, 1, 8'h00, 0, 1);
        exp_both("ld00", 8'h00, 0, 0, 8'h00, 0, 0);
        cyc(0, 0, 8'h00, 1, 1);
        exp_both("dn_lim", 8'h99, 1, 0, 8'h00, 1, 0);

        // Rejected loads hold the count and pulse load_err; en is ignored.
        cyc(0, 1, 8'h3A, 0, 0);
        exp_both("bad3A", 8'h99, 0, 1, 8'h00, 0, 1);
        cyc(0, 0, 8'h00, 0, 0);
        exp_both("errclr", 8'h99, 0, 0, 8'h00, 0, 0);
        cyc(0, 1, 8'hA3, 1, 0);
        exp_both("badA3", 8'h99, 0, 1, 8'h00, 0, 1);
        cyc(0, 1, 8'h42, 1, 0);
        exp_both("ld42en", 8'h42, 0, 0, 8'h42, 0, 0);

        // Back-to-back limit events, then direction change with no turnaround.
        cyc(0, 1, 8'h99, 0, 0);
        exp_both("ld99", 8'h99, 0, 0, 8'h99, 0, 0);
        cyc(0, 0, 8'h00, 1, 0);
        exp_both("sat1", 8'h00, 1, 0, 8'h99, 1, 0);
        cyc(0, 0, 8'h00, 1, 0);
        exp_both("sat2", 8'h01, 0, 0, 8'h99, 1, 0);
        cyc(0, 0, 8'h00, 1, 0);
        exp_both("sat3", 8'h02, 0, 0, 8'h99, 1, 0);
        cyc(0, 0, 8'h00, 1, 1);
        exp_both("satdn", 8'h01, 0, 0, 8'h98, 0, 0);

        // Reset mid-count coincident with load and en discards both.
        cyc(0, 1, 8'h56, 0, 0);
        cyc(0, 0, 8'h00, 1, 0);
        exp_both("cnt57", 8'h57, 0, 0, 8'h57, 0, 0);
        cyc(1, 1, 8'h12, 1, 0);
        exp_both("rstld", 8'h00, 0, 0, 8'h00, 0, 0);
        cyc(0, 0, 8'h00, 1, 0);
        exp_both("resume", 8'h01, 0, 0, 8'h01, 0, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/bcd_counter2.md
BCD_COUNTER2 -- requirements
Module: bcd_counter2

Interface
REQ-001 The block SHALL have parameter WRAP, default 1, where 1 wraps at the limits and 0 saturates at the limits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port en, input, 1 bit: count enable; one step per cycle while high.
REQ-005 The block SHALL have port d, input, 1 bit: direction; 0 counts up, 1 counts down.
REQ-006 The block SHALL have port load, input, 1 bit: synchronous load request.
REQ-007 The block SHALL have port load_val, input, 8 bits: [7:4] is the tens digit and [3:0] is the ones digit, both BCD.
REQ-008 The block SHALL have port ones, output, 4 bits: registered BCD ones digit, always in the range 0-9.
REQ-009 The block SHALL have port tens, output, 4 bits: registered BCD tens digit, always in the range 0-9.
REQ-010 The block SHALL have port tc, output, 1 bit: registered terminal-count pulse.
REQ-011 The block SHALL have port load_err, output, 1 bit: registered pulse flagging a rejected load.

Function
REQ-012 The count SHALL be the two-digit decimal value tens*10+ones, in the range 00-99.
REQ-013 Per-cycle priority SHALL be: reset, then load, then en; a lower-priority request is ignored in any cycle where a higher one is active.
REQ-014 On a load where both nibbles are 0-9, ones and tens SHALL take load_val on the next edge, with tc=0 and load_err=0.
REQ-015 On a load where either nibble is greater than 9, the count SHALL hold, load_err SHALL be 1 for exactly the next cycle, and no step SHALL occur even if en=1.
REQ-016 In an up step, ones SHALL increment, and ones=9 SHALL roll to 0 with a carry that increments tens.
REQ-017 In a down step, ones SHALL decrement, and ones=0 SHALL roll to 9 with a borrow that decrements tens.
REQ-018 With WRAP=1, stepping up at 99 SHALL give 00 and stepping down at 00 SHALL give 99, with tc=1 for exactly the one cycle following the wrap edge.
REQ-019 With WRAP=0, a step attempted at the limit (up at 99, down at 00) SHALL leave the count unchanged and SHALL pulse tc=1 for one cycle.
REQ-020 tc SHALL be 0 in every cycle not covered by REQ-018 or REQ-019; back-to-back limit events SHALL produce back-to-back tc pulses.
REQ-021 When en=0 and load=0, the count SHALL hold, and tc and load_err SHALL be 0 on the next edge.
REQ-022 A change of d SHALL take effect on the same edge it is sampled, with no turnaround cycle.
REQ-023 There SHALL be no combinational path from any input to any output; latency from input to output SHALL be 1 cycle.

Reset
REQ-024 While reset=1 at a rising edge, the next state SHALL be ones=0, tens=0, tc=0 and load_err=0, regardless of load or en.
REQ-025 Reset asserted mid-count or coincident with a load SHALL discard that operation.
REQ-026 Counting SHALL resume from 00 on the first edge after reset is deasserted.

Structure
REQ-027 A shared package bcd_pkg SHALL hold typedef bcd_t (logic[3:0]) and constants BCD_MIN=0 and BCD_MAX=9, for reuse by the downstream BCD-to-one-hot decoder.
REQ-028 One sub-module, bcd_digit, SHALL be instantiated twice (ones and tens).
REQ-029 bcd_digit SHALL take inputs step, d, load and load digit, and SHALL produce a registered digit plus combinational carry and borrow outputs.
REQ-030 The tens digit's step SHALL be the ones digit's carry (up) or borrow (down).
REQ-031 The top level SHALL own load validation, limit and saturation detection, and the tc and load_err registers.

Verification
REQ-032 Reset, then en=1, d=0 for 100 cycles -> count goes 00,01,...,99,00; tc=1 only in the cycle after 99->00.
REQ-033 Load 0x09, then d=0 for one step -> count 10; then d=1 for one step -> count 09; then load 0x00 and d=1 for one step -> count 99 with a tc pulse.
REQ-034 Load 0x3A -> load_err=1 for one cycle, count unchanged; then load 0xA3 -> same result; then load 0x42 with en=1 -> count 42 with no step that cycle.
REQ-035 WRAP=0: load 0x99 with en=1, d=0 for 3 cycles -> count stays 99 and tc=1 in each of the 3 following cycles; then d=1 -> count 98 and tc=0.
REQ-036 Count to 57, then assert reset together with load=1 (load_val=0x12) and en=1 -> count 00, tc=0, load_err=0; deassert reset -> count 01 on the next edge.
